// File: rtl/mem_stage_ctrl_pkg.sv
// Shared RV32I type definitions used by the memory stage.
package rv32i_types;

    // Load access encodings (funct3 of LOAD opcode).
    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    // Store access encodings (funct3 of STORE opcode).
    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    // Memory-stage handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/response bundle; master is the memory stage, slave the cache.
interface mem_stage_ctrl_if;
    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_mbe;
    logic        dcache_resp;
    logic [31:0] dcache_rdata;

    modport master (
        output dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_mbe,
        input  dcache_resp, dcache_rdata
    );

    modport slave (
        input  dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_mbe,
        output dcache_resp, dcache_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl_align.sv
// Byte-lane steering: store mask/shift, load extract/extend, misalignment detect.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] lane_data;

    // Store data moves into its lane; the addressed load lane moves down to bit 0.
    assign wdata     = rs2 << {off, 3'b000};
    assign lane_data = rdata >> {off, 3'b000};

    // Halfwords need even addresses, words need 4-byte alignment; bytes always fit.
    assign misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                        ((funct3[1:0] == 2'b10) && (off != 2'b00));

    // Byte-enable pattern follows access size; anything not byte/half writes the word.
    always_comb begin
        mbe = 4'b1111;
        case (funct3)
            sb:      mbe = 4'b0001 << off;
            sh:      mbe = 4'b0011 << off;
            default: mbe = 4'b1111;
        endcase
    end

    // Size-and-sign selection of the load result; unknown encodings return the raw word.
    always_comb begin
        load_data = rdata;
        case (funct3)
            lb:      load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            lh:      load_data = {{16{lane_data[15]}}, lane_data[15:0]};
            lbu:     load_data = {24'h000000, lane_data[7:0]};
            lhu:     load_data = {16'h0000, lane_data[15:0]};
            lw:      load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: cache handshake FSM, pipeline stall and load hold register.
module mem_stage_ctrl
    import rv32i_types::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MEM_valid,
    input  logic                    MEM_is_load,
    input  logic                    MEM_is_store,
    input  logic [2:0]              MEM_funct3,
    input  logic [31:0]             MEM_alu_out,
    input  logic [31:0]             MEM_rs2,
    input  logic                    advance,
    mem_stage_ctrl_if.master        dcache,
    output logic [31:0]             MEM_rdata,
    output logic                    mem_stall,
    output logic                    mem_misaligned
);

    mem_state_t  state_reg, state_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [31:0] load_data;
    logic        misaligned_raw;
    logic        op;
    logic        issue;

    mem_align u_align (
        .funct3     (MEM_funct3),
        .off        (MEM_alu_out[1:0]),
        .rs2        (MEM_rs2),
        .rdata      (dcache.dcache_rdata),
        .mbe        (dcache.dcache_mbe),
        .wdata      (dcache.dcache_wdata),
        .load_data  (load_data),
        .misaligned (misaligned_raw)
    );

    // Only real memory instructions can be flagged or issued.
    assign mem_misaligned = MEM_valid & (MEM_is_load | MEM_is_store) & misaligned_raw;
    assign op             = MEM_valid & (MEM_is_load | MEM_is_store) & ~mem_misaligned;

    assign dcache.dcache_address = {MEM_alu_out[31:2], 2'b00};
    assign MEM_rdata             = rdata_reg;

    // State and load-hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            rdata_reg <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;
        end
    end

    // Next state: DONE parks until the pipeline advances so the access is never replayed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op) state_next = dcache.dcache_resp ? DONE : WAIT;
            WAIT:    if (dcache.dcache_resp) state_next = DONE;
            DONE:    if (advance) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: request is live from the issue cycle through resp; reset kills it at once.
    always_comb begin
        issue = 1'b0;
        case (state_reg)
            IDLE:    issue = op;
            WAIT:    issue = 1'b1;
            default: issue = 1'b0;
        endcase
        if (reset) issue = 1'b0;
        dcache.dcache_read  = issue & MEM_is_load;
        dcache.dcache_write = issue & MEM_is_store;
        mem_stall           = issue;
        rdata_next          = rdata_reg;
        if (issue & MEM_is_load & dcache.dcache_resp) rdata_next = load_data;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench: stimulus pushes expected cache transactions, a monitor checks them.
module tb_mem_stage_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic [31:0] rdata_after;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        MEM_valid, MEM_is_load, MEM_is_store;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_out, MEM_rs2;
    logic        advance;
    logic [31:0] MEM_rdata;
    logic        mem_stall, mem_misaligned;

    int          n_checks;
    int          n_errors;
    exp_t        exp_q[$];
    logic [31:0] model_rdata;

    mem_stage_ctrl_if dif();

    mem_stage_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_valid      (MEM_valid),
        .MEM_is_load    (MEM_is_load),
        .MEM_is_store   (MEM_is_store),
        .MEM_funct3     (MEM_funct3),
        .MEM_alu_out    (MEM_alu_out),
        .MEM_rs2        (MEM_rs2),
        .advance        (advance),
        .dcache         (dif),
        .MEM_rdata      (MEM_rdata),
        .mem_stall      (mem_stall),
        .mem_misaligned (mem_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        MEM_valid    = 1'b0;
        MEM_is_load  = 1'b0;
        MEM_is_store = 1'b0;
        MEM_funct3   = 3'b000;
        MEM_alu_out  = 32'h0;
        MEM_rs2      = 32'h0;
        dif.dcache_resp  = 1'b0;
        dif.dcache_rdata = 32'h0;
    endtask

    // One access: resp arrives lat cycles after issue, then hold+1 cycles in DONE.
    task automatic access(input string name, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [31:0] rd, input int lat,
                          input logic [31:0] exp_wd, input logic [3:0] exp_mbe,
                          input logic [31:0] exp_rd, input int hold);
        exp_t e;
        e.rd = ld; e.wr = st; e.addr = {a[31:2], 2'b00};
        e.wdata = exp_wd; e.mbe = exp_mbe; e.rdata_after = exp_rd;
        exp_q.push_back(e);
        model_rdata = exp_rd;
        MEM_valid = 1'b1; MEM_is_load = ld; MEM_is_store = st;
        MEM_funct3 = f3; MEM_alu_out = a; MEM_rs2 = rs2;
        dif.dcache_resp  = (lat == 0);
        dif.dcache_rdata = (lat == 0) ? rd : 32'h0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk({name, "_stall"}, 32'(mem_stall), 32'd1);
            chk({name, "_read"},  32'(dif.dcache_read), 32'(ld));
            chk({name, "_write"}, 32'(dif.dcache_write), 32'(st));
            chk({name, "_addr"},  dif.dcache_address, {a[31:2], 2'b00});
            @(posedge clk); #1;
            dif.dcache_resp  = (c + 1 == lat);
            dif.dcache_rdata = (c + 1 == lat) ? rd : 32'h0;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) advance = 1'b1;
            @(negedge clk);
            chk({name, "_done_stall"}, 32'(mem_stall), 32'd0);
            chk({name, "_done_noreq"}, 32'(dif.dcache_read | dif.dcache_write), 32'd0);
            chk({name, "_done_rdata"}, MEM_rdata, exp_rd);
            @(posedge clk); #1;
        end
        advance = 1'b0;
        clear_inputs();
        $display("txn %s addr=%h ld=%0b st=%0b lat=%0d rdata=%h", name, a, ld, st, lat, MEM_rdata);
    endtask

    // A misaligned access must pass through without touching the cache or the hold register.
    task automatic misaligned_access(input string name, input logic [2:0] f3, input logic [31:0] a);
        MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_is_store = 1'b0;
        MEM_funct3 = f3; MEM_alu_out = a;
        dif.dcache_resp = 1'b0;
        advance = 1'b1;
        @(negedge clk);
        chk({name, "_flag"},  32'(mem_misaligned), 32'd1);
        chk({name, "_stall"}, 32'(mem_stall), 32'd0);
        chk({name, "_noreq"}, 32'(dif.dcache_read | dif.dcache_write), 32'd0);
        @(posedge clk); #1;
        advance = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk({name, "_rdata"}, MEM_rdata, model_rdata);
        @(posedge clk); #1;
        $display("txn %s addr=%h misaligned rdata=%h", name, a, MEM_rdata);
    endtask

    // Monitor: every completed cache handshake is matched against the scoreboard.
    initial begin
        logic        pend;
        logic [31:0] pend_rd;
        exp_t        e;
        pend = 1'b0;
        pend_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("mon_hold_rdata", MEM_rdata, pend_rd);
                pend = 1'b0;
            end
            if (!reset && (dif.dcache_read || dif.dcache_write) && dif.dcache_resp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon_unexpected: got request addr %h expected none", dif.dcache_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_read",  32'(dif.dcache_read), 32'(e.rd));
                    chk("mon_write", 32'(dif.dcache_write), 32'(e.wr));
                    chk("mon_addr",  dif.dcache_address, e.addr);
                    if (e.wr) begin
                        chk("mon_wdata", dif.dcache_wdata, e.wdata);
                        chk("mon_mbe",   32'(dif.dcache_mbe), 32'(e.mbe));
                    end
                    pend = 1'b1;
                    pend_rd = e.rdata_after;
                end
            end
        end
    end

    // Protocol guard: the pipeline must never advance while the stage is stalled.
    always @(negedge clk) begin
        if (!reset && advance && mem_stall) begin
            n_errors++;
            $display("FAIL advance_during_stall: got advance=1 expected 0 at %0t", $time);
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_rdata = 32'h0;
        advance = 1'b0;
        clear_inputs();
        reset = 1'b1;
        // A valid load during reset must still produce no request and no stall.
        MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_funct3 = 3'b010; MEM_alu_out = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rdata", MEM_rdata, 32'h0);
        chk("rst_read",  32'(dif.dcache_read), 32'd0);
        chk("rst_write", 32'(dif.dcache_write), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b0;
        @(posedge clk); #1;

        access("lw_hit",   1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
        access("lb_neg",   1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 32'h0, 4'h0, 32'hFFFF_FF80, 0);
        access("lbu",      1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 32'h0, 4'h0, 32'h0000_0080, 0);
        access("lh_neg",   1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_0000, 2, 32'h0, 4'h0, 32'hFFFF_80FF, 0);
        access("lhu",      1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_0000, 0, 32'h0, 4'h0, 32'h0000_80FF, 0);
        access("lh_pos",   1, 0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_7FFE, 0, 32'h0, 4'h0, 32'h0000_7FFE, 0);
        access("sh_miss",  0, 1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 5, 32'h1234_0000, 4'b1100, 32'h0000_7FFE, 0);
        access("sb",       0, 1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, 32'h0000_AB00, 4'b0010, 32'h0000_7FFE, 0);
        access("sw",       0, 1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'h0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0000_7FFE, 0);

        misaligned_access("lw_mis", 3'b010, 32'h0000_0101);
        misaligned_access("lh_mis", 3'b001, 32'h0000_0103);

        // Resp lands while advance stays low: DONE must hold without reissuing.
        access("lw_park",  1, 0, 3'b010, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 3);
        // Back in IDLE: an immediate follow-up load must issue straight away.
        access("lw_next",  1, 0, 3'b010, 32'h0000_010C, 32'h0, 32'h1357_9BDF, 0, 32'h0, 4'h0, 32'h1357_9BDF, 0);

        // Non-memory instruction.
        MEM_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("alu_stall", 32'(mem_stall), 32'd0);
            chk("alu_noreq", 32'(dif.dcache_read | dif.dcache_write), 32'd0);
            @(posedge clk); #1;
        end
        clear_inputs();
        $display("txn alu_op stall=%0b", mem_stall);

        // Reset in the middle of a miss.
        MEM_valid = 1'b1; MEM_is_load = 1'b1; MEM_funct3 = 3'b010; MEM_alu_out = 32'h0000_0200;
        @(negedge clk);
        chk("rw_idle_read", 32'(dif.dcache_read), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wait_read",  32'(dif.dcache_read), 32'd1);
        chk("rw_wait_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rw_rst_read",  32'(dif.dcache_read), 32'd0);
        chk("rw_rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_inputs();
        model_rdata = 32'h0;
        @(negedge clk);
        chk("rw_after_rdata", MEM_rdata, 32'h0);
        chk("rw_after_read",  32'(dif.dcache_read), 32'd0);
        chk("rw_after_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        $display("txn reset_in_wait rdata=%h", MEM_rdata);

        access("lw_postrst", 1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h55AA_55AA, 2, 32'h0, 4'h0, 32'h55AA_55AA, 0);

        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
